seg7_scan_arbiter: RTL and testbench



---
 rtl/seg7_scan_arbiter.sv | 150 +++++++++++++++
 tb/tb_seg7_scan_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_arbiter.sv
// Scan controller for the 8-digit common-anode display, shared between debug and MMIO sources.
// Each frame starts from a one-cycle snapshot, so a frame never mixes two values.
module seg7_scan_arbiter #(
  parameter int DIGIT_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic        clk_7seg,
  input  logic        Rst,
  input  logic        en,
  input  logic        dbg_req,
  input  logic [31:0] dbg_data,
  input  logic [31:0] mmio_data,
  input  logic        lz_en,
  output logic [7:0]  an,
  output logic [6:0]  sev_out,
  output logic        cur_src,
  output logic        frame_done
);

  localparam int DW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [DW-1:0] LAST_DWELL = DW'(DIGIT_CYCLES - 1);
  localparam logic [DW-1:0] ONE_DWELL  = DW'(1);
  localparam logic [DW-1:0] ZERO_DWELL = DW'(0);

  typedef enum logic {
    SNAP = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t         state_r, state_s;
  logic [2:0]     digit_r, digit_s;
  logic [DW-1:0]  dwell_r, dwell_s;
  logic [31:0]    snap_r, snap_s;
  logic [7:0]     mask_r, mask_s;
  logic           src_s;
  logic           lit_s;
  logic [7:0]     an_s;
  logic [6:0]     sev_s;
  logic           done_s;
  logic [31:0]    sel_s;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // A digit is kept when it or any higher nibble is nonzero; digit 0 is always kept.
  function automatic logic [7:0] lz_mask(input logic [31:0] value, input logic lz);
    logic [7:0] keep;
    keep[7] = |value[31:28];
    for (int k = 6; k >= 0; k--) begin
      keep[k] = keep[k+1] | (|value[k*4 +: 4]);
    end
    keep[0] = 1'b1;
    return lz ? ~keep : 8'h00;
  endfunction

  // Next phase, snapshot and the output values that belong to that phase.
  always_comb begin
    state_s = state_r;
    digit_s = digit_r;
    dwell_s = dwell_r;
    snap_s  = snap_r;
    mask_s  = mask_r;
    src_s   = cur_src;
    sel_s   = dbg_req ? dbg_data : mmio_data;
    case (state_r)
      SNAP: begin
        if (en) begin
          state_s = SCAN;
          digit_s = 3'd0;
          dwell_s = ZERO_DWELL;
          snap_s  = sel_s;
          mask_s  = lz_mask(sel_s, lz_en);
          src_s   = dbg_req;
        end else begin
          state_s = SNAP;
        end
      end
      SCAN: begin
        if (dwell_r == LAST_DWELL) begin
          dwell_s = ZERO_DWELL;
          if (digit_r == 3'd7) begin
            state_s = SNAP;
            digit_s = 3'd0;
          end else begin
            digit_s = digit_r + 3'd1;
          end
        end else begin
          dwell_s = dwell_r + ONE_DWELL;
        end
      end
      default: begin
        state_s = SNAP;
        digit_s = 3'd0;
        dwell_s = ZERO_DWELL;
      end
    endcase

    lit_s  = (state_s == SCAN) && (int'(dwell_s) >= BLANK_CYCLES);
    an_s   = (lit_s && !mask_s[digit_s]) ? ~(8'd1 << digit_s) : 8'hFF;
    sev_s  = lit_s ? seg_decode(snap_s[{digit_s, 2'b00} +: 4]) : 7'h7F;
    done_s = (state_s == SCAN) && (digit_s == 3'd7) && (dwell_s == LAST_DWELL);
  end

  // Phase registers and display outputs advance together on every edge.
  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      state_r    <= SNAP;
      digit_r    <= 3'd0;
      dwell_r    <= ZERO_DWELL;
      snap_r     <= 32'd0;
      mask_r     <= 8'h00;
      cur_src    <= 1'b0;
      an         <= 8'hFF;
      sev_out    <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_s;
      digit_r    <= digit_s;
      dwell_r    <= dwell_s;
      snap_r     <= snap_s;
      mask_r     <= mask_s;
      cur_src    <= src_s;
      an         <= an_s;
      sev_out    <= sev_s;
      frame_done <= done_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan_arbiter.sv
// Self-checking bench: two instances (default timing and 1-cycle/no-blank timing) against a frame-offset model.
module tb_seg7_scan_arbiter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        dbg_req;
  logic [31:0] dbg_data;
  logic [31:0] mmio_data;
  logic        lz_en;
  logic [7:0]  an0, an1;
  logic [6:0]  sev0, sev1;
  logic        src0, src1;
  logic        fd0, fd1;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int          dc[2] = '{4, 1};
  int          bc[2] = '{1, 0};
  int          t[2];
  logic [31:0] snap[2];
  logic        lzl[2];
  logic        cur[2];

  logic [6:0] seg_tab[16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seg7_scan_arbiter #(.DIGIT_CYCLES(4), .BLANK_CYCLES(1)) dut (
    .clk_7seg(clk), .Rst(rst), .en(en), .dbg_req(dbg_req), .dbg_data(dbg_data),
    .mmio_data(mmio_data), .lz_en(lz_en), .an(an0), .sev_out(sev0),
    .cur_src(src0), .frame_done(fd0)
  );

  seg7_scan_arbiter #(.DIGIT_CYCLES(1), .BLANK_CYCLES(0)) dut1 (
    .clk_7seg(clk), .Rst(rst), .en(en), .dbg_req(dbg_req), .dbg_data(dbg_data),
    .mmio_data(mmio_data), .lz_en(lz_en), .an(an1), .sev_out(sev1),
    .cur_src(src1), .frame_done(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // t = cycle offset inside the frame, 0 = snapshot cycle.
  task automatic model_edge(input int i);
    if (rst) begin
      t[i] = 0;
      cur[i] = 1'b0;
    end else if (t[i] == 0) begin
      if (en) begin
        snap[i] = dbg_req ? dbg_data : mmio_data;
        cur[i]  = dbg_req;
        lzl[i]  = lz_en;
        t[i]    = 1;
      end
    end else if (t[i] == 8 * dc[i]) begin
      t[i] = 0;
    end else begin
      t[i] = t[i] + 1;
    end
  endtask

  task automatic expect_out(input int i, output logic [7:0] ea, output logic [6:0] es, output logic ef);
    int k;
    int d;
    logic [31:0] upper;
    logic [3:0] nib;
    ea = 8'hFF;
    es = 7'h7F;
    ef = 1'b0;
    if (t[i] > 0) begin
      k = (t[i] - 1) / dc[i];
      d = (t[i] - 1) % dc[i];
      ef = (t[i] == 8 * dc[i]);
      upper = snap[i] >> (4 * k);
      nib = upper[3:0];
      if (d >= bc[i]) begin
        es = seg_tab[nib];
        if (!(lzl[i] && k > 0 && upper == 32'd0)) ea = ~(8'd1 << k);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h time=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    logic [7:0] ea;
    logic [6:0] es;
    logic ef;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    expect_out(0, ea, es, ef);
    check("an_d4", {24'd0, an0}, {24'd0, ea});
    check("sev_d4", {25'd0, sev0}, {25'd0, es});
    check("done_d4", {31'd0, fd0}, {31'd0, ef});
    check("src_d4", {31'd0, src0}, {31'd0, cur[0]});
    expect_out(1, ea, es, ef);
    check("an_d1", {24'd0, an1}, {24'd0, ea});
    check("sev_d1", {25'd0, sev1}, {25'd0, es});
    check("done_d1", {31'd0, fd1}, {31'd0, ef});
    check("src_d1", {31'd0, src1}, {31'd0, cur[1]});
  endtask

  initial begin
    t[0] = 0; t[1] = 0;
    snap[0] = 32'd0; snap[1] = 32'd0;
    lzl[0] = 1'b0; lzl[1] = 1'b0;
    cur[0] = 1'b0; cur[1] = 1'b0;
    rst = 1'b1; en = 1'b1; dbg_req = 1'b0; dbg_data = 32'd0;
    mmio_data = 32'h12345678; lz_en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (18) tick();
    // Reset lands in digit 4 of the default instance.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    dbg_req = 1'b1;
    dbg_data = 32'hDEADBEEF;
    repeat (23) tick();
    repeat (34) tick();
    check("frame_src_dbg", {31'd0, src0}, 32'd1);
    dbg_req = 1'b0;
    lz_en = 1'b1;
    mmio_data = 32'h000000A0;
    repeat (66) tick();
    mmio_data = 32'h00000000;
    repeat (66) tick();
    lz_en = 1'b0;
    mmio_data = 32'h11111111;
    repeat (15) tick();
    mmio_data = 32'h22222222;
    repeat (60) tick();
    en = 1'b0;
    repeat (40) tick();
    check("idle_an", {24'd0, an0}, 32'h000000FF);
    en = 1'b1;
    repeat (10) tick();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 7) != 0);
      dbg_req = $urandom_range(0, 1) == 1;
      lz_en = $urandom_range(0, 1) == 1;
      dbg_data = $urandom >> ($urandom_range(0, 8) * 4);
      mmio_data = $urandom >> ($urandom_range(0, 8) * 4);
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
